// File: rtl/inst_decode_stage.sv
// MIPS instruction decode stage: a small circular FIFO of pre-decoded records.
// Each entry holds the raw instruction word plus its extended immediate and
// its class. The fields are computed at enqueue, so the outputs are plain
// slices of the head entry and involve no logic after the storage.
module inst_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               sa,
  output logic [5:0]               funct,
  output logic [15:0]              immediate,
  output logic [25:0]              inst_index,
  output logic [XLEN-1:0]          ext_imm,
  output logic [1:0]               iclass,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] CLS_R = 2'd0;
  localparam logic [1:0] CLS_I = 2'd1;
  localparam logic [1:0] CLS_J = 2'd2;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] ext_imm;
    logic [1:0]      iclass;
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            in_rec;
  rec_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] sext;
  logic            push, pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  // Full blocks a push even when a pop happens in the same cycle.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign sext = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};

  // Decode the incoming word into the record that will be stored.
  always_comb begin
    in_rec      = '0;
    in_rec.inst = in_inst;
    case (in_inst[31:26])
      6'h0C, 6'h0D, 6'h0E: in_rec.ext_imm = {{(XLEN-16){1'b0}}, in_inst[15:0]};
      // lui: imm in the upper half of the low word, sign-extended above it.
      6'h0F:               in_rec.ext_imm = sext << 16;
      default:             in_rec.ext_imm = sext;
    endcase
    case (in_inst[31:26])
      6'h00:        in_rec.iclass = CLS_R;
      6'h02, 6'h03: in_rec.iclass = CLS_J;
      default:      in_rec.iclass = CLS_I;
    endcase
  end

  // Entry storage; cleared on reset so the idle outputs are never X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_rec;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign opcode     = head.inst[31:26];
  assign rs         = head.inst[25:21];
  assign rt         = head.inst[20:16];
  assign rd         = head.inst[15:11];
  assign sa         = head.inst[10:6];
  assign funct      = head.inst[5:0];
  assign immediate  = head.inst[15:0];
  assign inst_index = head.inst[25:0];
  assign ext_imm    = head.ext_imm;
  assign iclass     = head.iclass;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: a queue model of the FIFO with decode rules
// computed arithmetically, checked every cycle, plus literal spot checks.
module tb_inst_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   flush, in_valid, out_ready;
  logic [31:0]            in_inst;
  logic                   in_ready, out_valid;
  logic [5:0]             opcode, funct;
  logic [4:0]             rs, rt, rd, sa;
  logic [15:0]            immediate;
  logic [25:0]            inst_index;
  logic [XLEN-1:0]        ext_imm;
  logic [1:0]             iclass;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  inst_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
    .immediate(immediate), .inst_index(inst_index),
    .ext_imm(ext_imm), .iclass(iclass), .count(count)
  );

  // Expected extended immediate, as a 64-bit two's-complement value cut to XLEN.
  function automatic logic [63:0] exp_ext(input logic [31:0] i);
    longint v;
    logic [15:0] imm;
    logic [5:0]  op;
    imm = i[15:0];
    op  = i[31:26];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) v = longint'(imm);
    else if (op == 6'h0F) v = longint'(int'(imm) * 65536) << 32 >>> 32;
    else v = longint'($signed(imm));
    if (XLEN == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  function automatic logic [1:0] exp_cls(input logic [31:0] i);
    int op;
    op = int'(i[31:26]);
    if (op == 0) return 2'd0;
    if (op == 2 || op == 3) return 2'd2;
    return 2'd1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic compare();
    logic [31:0] h;
    if (!rstn) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_count",     64'(count),     64'd0);
      chk("rst_inst_index",64'(inst_index),64'd0);
      chk("rst_opcode",    64'(opcode),    64'd0);
      chk("rst_ext_imm",   64'(ext_imm),   64'd0);
      chk("rst_iclass",    64'(iclass),    64'd0);
    end else begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready",  64'(in_ready),  64'(q.size() < DEPTH));
      chk("count",     64'(count),     64'(q.size()));
      if (q.size() != 0) begin
        h = q[0];
        chk("opcode",     64'(opcode),     64'(h >> 26));
        chk("rs",         64'(rs),         64'((h >> 21) & 32'h1F));
        chk("rt",         64'(rt),         64'((h >> 16) & 32'h1F));
        chk("rd",         64'(rd),         64'((h >> 11) & 32'h1F));
        chk("sa",         64'(sa),         64'((h >> 6) & 32'h1F));
        chk("funct",      64'(funct),      64'(h & 32'h3F));
        chk("immediate",  64'(immediate),  64'(h & 32'hFFFF));
        chk("inst_index", 64'(inst_index), 64'(h & 32'h03FF_FFFF));
        chk("ext_imm",    64'(ext_imm),    exp_ext(h));
        chk("iclass",     64'(iclass),     64'(exp_cls(h)));
      end
    end
  endtask

  // Hold inputs for one cycle, check at the falling edge, advance the model
  // at the rising edge, return just after it.
  task automatic step(input logic v, input logic [31:0] inst, input logic ordy, input logic fl);
    bit full, do_pop, do_push;
    in_valid = v; in_inst = inst; out_ready = ordy; flush = fl;
    @(negedge clk);
    compare();
    @(posedge clk);
    if (rstn) begin
      full    = (q.size() >= DEPTH);
      do_pop  = (q.size() != 0) && ordy && !fl;
      do_push = v && !full && !fl;
      if (fl) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(inst);
      end
    end
    #1;
  endtask

  initial begin
    logic [5:0]  ops [10];
    logic [31:0] r;
    logic [5:0]  op;
    ops = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    rstn = 1'b0;
    step(0, 32'h0, 0, 0);
    step(1, 32'hDEAD_BEEF, 1, 0);
    rstn = 1'b1;

    // R-type field slicing, one-cycle latency
    step(1, 32'h00C2_1004, 1, 0);
    chk("r_out_valid", 64'(out_valid), 64'd1);
    chk("r_opcode", 64'(opcode), 64'd0);
    chk("r_rs", 64'(rs), 64'd6);
    chk("r_rt", 64'(rt), 64'd2);
    chk("r_rd", 64'(rd), 64'd2);
    chk("r_sa", 64'(sa), 64'd0);
    chk("r_funct", 64'(funct), 64'd4);
    chk("r_iclass", 64'(iclass), 64'd0);

    // Immediate extension variants, streamed back to back
    step(1, 32'h2008_FFFF, 1, 0);
    chk("addi_ext", 64'(ext_imm), 64'hFFFF_FFFF);
    step(1, 32'h3408_FFFF, 1, 0);
    chk("ori_ext", 64'(ext_imm), 64'h0000_FFFF);
    step(1, 32'h3C08_8001, 1, 0);
    chk("lui_ext", 64'(ext_imm), 64'h8001_0000);
    step(1, 32'h0C10_0004, 1, 0);
    chk("jal_iclass", 64'(iclass), 64'd2);
    chk("jal_index", 64'(inst_index), 64'h010_0004);
    step(0, 32'h0, 1, 0);
    chk("drained", 64'(out_valid), 64'd0);

    // Fill to full, third push dropped, then drain in order
    step(1, 32'h2001_0011, 0, 0);
    step(1, 32'h2002_0022, 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    step(1, 32'h2003_0033, 0, 0);
    chk("drop_count", 64'(count), 64'd2);
    chk("hold_head", 64'(immediate), 64'h11);
    step(1, 32'h2004_0044, 1, 0);
    chk("full_pop_nopush", 64'(count), 64'd1);
    chk("second_head", 64'(immediate), 64'h22);
    step(0, 32'h0, 1, 0);
    chk("empty_after", 64'(count), 64'd0);
    step(0, 32'h0, 1, 0);
    chk("no_underflow", 64'(count), 64'd0);

    // Streaming: one in, one out per cycle
    for (int k = 0; k < 8; k++) begin
      step(1, 32'h2000_0100 + 32'(k), 1, 0);
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    step(0, 32'h0, 1, 0);

    // Flush dominates a concurrent push
    step(1, 32'h2001_0011, 0, 0);
    step(1, 32'h2002_0022, 0, 0);
    step(1, 32'h2003_0033, 1, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset between clock edges
    step(1, 32'h2001_0011, 0, 0);
    step(1, 32'h2002_0022, 0, 0);
    #2 rstn = 1'b0;
    q.delete();
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_imm", 64'(immediate), 64'd0);
    chk("arst_ext", 64'(ext_imm), 64'd0);
    step(1, 32'h2005_0055, 1, 0);
    rstn = 1'b1;
    step(1, 32'h3C08_8001, 1, 0);
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_ext", 64'(ext_imm), 64'h8001_0000);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = r[31:26];
      step($urandom_range(0, 3) != 0, {op, r[25:0]},
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
